// File: rtl/iob_cache_write_buffer_channel_pkg.sv
// Shared constants for the cache back-end write channel: write-policy codes
// and write-back sequencer state encodings.
package iob_cache_write_buffer_channel_pkg;

  localparam int WRITE_THROUGH = 0;
  localparam int WRITE_BACK    = 1;

  typedef enum logic {
    WB_IDLE = 1'b0,
    WB_BUSY = 1'b1
  } wb_state_e;

endpackage

// File: rtl/iob_cache_write_buffer_channel_wbuf.sv
// Write-through post FIFO: addr/data/strobe entries, tail-entry merge and an
// occupancy count. The head entry is what the back end currently sees.
module iob_cache_wbuf #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int STRB_W   = 4,
  parameter int DEPTH_W  = 2,
  parameter int MERGE_EN = 1
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               push_i,
  input  logic [ADDR_W-1:0]  addr_i,
  input  logic [DATA_W-1:0]  data_i,
  input  logic [STRB_W-1:0]  strb_i,
  input  logic               pop_i,
  output logic               full_o,
  output logic               merge_hit_o,
  output logic [DEPTH_W:0]   count_o,
  output logic [ADDR_W-1:0]  head_addr_o,
  output logic [DATA_W-1:0]  head_data_o,
  output logic [STRB_W-1:0]  head_strb_o
);

  localparam int DEPTH  = 2 ** DEPTH_W;
  localparam int BYTE_W = DATA_W / STRB_W;

  logic [ADDR_W-1:0]  addr_q [DEPTH];
  logic [DATA_W-1:0]  data_q [DEPTH];
  logic [STRB_W-1:0]  strb_q [DEPTH];
  logic [DEPTH_W-1:0] wr_ptr_q, rd_ptr_q, tail_ptr;
  logic [DEPTH_W:0]   count_q;
  logic               do_write, do_merge, do_pop;

  assign tail_ptr = wr_ptr_q - 1'b1;
  assign full_o   = (count_q == (DEPTH_W+1)'(DEPTH));
  // With fewer than two entries the tail is the head, which must stay frozen.
  assign merge_hit_o = (MERGE_EN != 0) && (count_q >= (DEPTH_W+1)'(2)) &&
                       (addr_q[tail_ptr] == addr_i);

  assign do_write = push_i && !merge_hit_o && !full_o;
  assign do_merge = push_i && merge_hit_o;
  assign do_pop   = pop_i && (count_q != '0);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_write) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_write, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_write) begin
      addr_q[wr_ptr_q] <= addr_i;
      data_q[wr_ptr_q] <= data_i;
      strb_q[wr_ptr_q] <= strb_i;
    end else if (do_merge) begin
      strb_q[tail_ptr] <= strb_q[tail_ptr] | strb_i;
      for (int b = 0; b < STRB_W; b++) begin
        if (strb_i[b]) data_q[tail_ptr][b*BYTE_W +: BYTE_W] <= data_i[b*BYTE_W +: BYTE_W];
      end
    end
  end

  assign count_o     = count_q;
  assign head_addr_o = addr_q[rd_ptr_q];
  assign head_data_o = data_q[rd_ptr_q];
  assign head_strb_o = strb_q[rd_ptr_q];

endmodule

// File: rtl/iob_cache_write_buffer_channel.sv
// Cache back-end write channel: posted write-through FIFO or write-back line
// drainer, selected at elaboration by WRITE_POL.
module iob_cache_write_buffer_channel
  import iob_cache_write_buffer_channel_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int FE_DATA_W     = 32,
  parameter int BE_ADDR_W     = 32,
  parameter int BE_DATA_W     = 32,
  parameter int WRITE_POL     = 0,
  parameter int WORD_OFFSET_W = 3,
  parameter int WBUF_DEPTH_W  = 2,
  parameter int MERGE_EN      = 1,
  localparam int FE_NBYTES    = FE_DATA_W / 8,
  localparam int FE_NBYTES_W  = $clog2(FE_NBYTES),
  localparam int BE_NBYTES    = BE_DATA_W / 8,
  localparam int BE_NBYTES_W  = $clog2(BE_NBYTES),
  localparam int IN_ADDR_W    = ADDR_W - FE_NBYTES_W - WRITE_POL * WORD_OFFSET_W,
  localparam int IN_DATA_W    = FE_DATA_W * (2 ** (WRITE_POL * WORD_OFFSET_W))
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 valid_i,
  input  logic [IN_ADDR_W-1:0] addr_i,
  input  logic [FE_NBYTES-1:0] wstrb_i,
  input  logic [IN_DATA_W-1:0] wdata_i,
  output logic                 ready_o,
  output logic                 empty_o,
  output logic                 be_valid_o,
  output logic [BE_ADDR_W-1:0] be_addr_o,
  output logic [BE_DATA_W-1:0] be_wdata_o,
  output logic [BE_NBYTES-1:0] be_wstrb_o,
  input  logic                 be_ack_i
);

  localparam int RATIO   = BE_DATA_W / FE_DATA_W;
  localparam int RATIO_W = $clog2(RATIO);

  if (WRITE_POL == WRITE_THROUGH) begin : g_wt
    logic [ADDR_W-1:0]          fe_byte_addr;
    logic [ADDR_W-1:0]          be_word_addr;
    logic [BE_ADDR_W-1:0]       entry_addr;
    logic [BE_DATA_W-1:0]       entry_data;
    logic [BE_NBYTES-1:0]       entry_strb;
    logic                       full, merge_hit, push;
    logic [WBUF_DEPTH_W:0]      count;
    logic [BE_ADDR_W-1:0]       head_addr;
    logic [BE_DATA_W-1:0]       head_data;
    logic [BE_NBYTES-1:0]       head_strb;

    assign fe_byte_addr = ADDR_W'(addr_i) << FE_NBYTES_W;
    assign be_word_addr = (fe_byte_addr >> BE_NBYTES_W) << BE_NBYTES_W;
    assign entry_addr   = BE_ADDR_W'(be_word_addr);
    assign entry_data   = {RATIO{wdata_i}};
    // Byte offset inside the BE word is a multiple of FE_NBYTES, so it
    // positions the FE strobes onto the correct lane directly.
    assign entry_strb   = BE_NBYTES'(wstrb_i) << fe_byte_addr[BE_NBYTES_W-1:0];

    assign ready_o = ~full | merge_hit;
    assign push    = valid_i & ready_o & (|wstrb_i);

    iob_cache_wbuf #(
      .ADDR_W   (BE_ADDR_W),
      .DATA_W   (BE_DATA_W),
      .STRB_W   (BE_NBYTES),
      .DEPTH_W  (WBUF_DEPTH_W),
      .MERGE_EN (MERGE_EN)
    ) u_wbuf (
      .clk_i       (clk_i),
      .rst_n_i     (rst_n_i),
      .push_i      (push),
      .addr_i      (entry_addr),
      .data_i      (entry_data),
      .strb_i      (entry_strb),
      .pop_i       (be_ack_i),
      .full_o      (full),
      .merge_hit_o (merge_hit),
      .count_o     (count),
      .head_addr_o (head_addr),
      .head_data_o (head_data),
      .head_strb_o (head_strb)
    );

    assign empty_o    = (count == '0);
    assign be_valid_o = ~empty_o;
    assign be_addr_o  = head_addr;
    assign be_wdata_o = head_data;
    assign be_wstrb_o = be_valid_o ? head_strb : '0;
  end else if (WRITE_POL == WRITE_BACK) begin : g_wb
    localparam int LINE2BE_W = WORD_OFFSET_W - RATIO_W;
    localparam int BEAT_W    = (LINE2BE_W > 0) ? LINE2BE_W : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'((2 ** LINE2BE_W) - 1);

    wb_state_e            state_q;
    logic [BEAT_W-1:0]    beat_q;
    logic [IN_DATA_W-1:0] line_q;
    logic [IN_ADDR_W-1:0] line_addr_q;
    logic                 last_beat;
    logic                 unused_wstrb;

    assign last_beat    = (beat_q == LAST_BEAT);
    assign unused_wstrb = ^wstrb_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        state_q     <= WB_IDLE;
        beat_q      <= '0;
        line_q      <= '0;
        line_addr_q <= '0;
      end else begin
        case (state_q)
          WB_IDLE: if (valid_i) begin
            state_q     <= WB_BUSY;
            beat_q      <= '0;
            line_q      <= wdata_i;
            line_addr_q <= addr_i;
          end
          WB_BUSY: if (be_ack_i) begin
            beat_q <= last_beat ? '0 : beat_q + 1'b1;
            if (last_beat) state_q <= WB_IDLE;
          end
          default: state_q <= WB_IDLE;
        endcase
      end
    end

    assign ready_o    = (state_q == WB_IDLE);
    assign empty_o    = (state_q == WB_IDLE);
    assign be_valid_o = (state_q == WB_BUSY);
    assign be_addr_o  = BE_ADDR_W'((ADDR_W'(line_addr_q) << (ADDR_W - IN_ADDR_W)) |
                                   (ADDR_W'(beat_q) << BE_NBYTES_W));
    assign be_wdata_o = line_q[beat_q*BE_DATA_W +: BE_DATA_W];
    assign be_wstrb_o = {BE_NBYTES{be_valid_o}};
  end

endmodule

// File: tb/tb_iob_cache_write_buffer_channel.sv
// Bench for the write channel: write-through at BE=32 and BE=128, and
// write-back with a 256-bit line drained over a 32-bit back end.
module tb_iob_cache_write_buffer_channel;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // write-through, BE=FE=32, depth 4, merge on
  logic        a_valid, a_ready, a_empty, a_bvalid, a_ack;
  logic [29:0] a_addr;
  logic [3:0]  a_wstrb, a_bstrb;
  logic [31:0] a_wdata, a_baddr, a_bdata;
  // write-through, BE=128
  logic         b_valid, b_ready, b_empty, b_bvalid, b_ack;
  logic [29:0]  b_addr;
  logic [3:0]   b_wstrb;
  logic [31:0]  b_wdata, b_baddr;
  logic [127:0] b_bdata;
  logic [15:0]  b_bstrb;
  // write-back, 256-bit line, BE=32
  logic         c_valid, c_ready, c_empty, c_bvalid, c_ack;
  logic [26:0]  c_addr;
  logic [3:0]   c_wstrb, c_bstrb;
  logic [255:0] c_wdata;
  logic [31:0]  c_baddr, c_bdata;

  iob_cache_write_buffer_channel #(.BE_DATA_W(32), .WRITE_POL(0), .WBUF_DEPTH_W(2), .MERGE_EN(1)) u_wt32 (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(a_valid), .addr_i(a_addr), .wstrb_i(a_wstrb),
    .wdata_i(a_wdata), .ready_o(a_ready), .empty_o(a_empty), .be_valid_o(a_bvalid),
    .be_addr_o(a_baddr), .be_wdata_o(a_bdata), .be_wstrb_o(a_bstrb), .be_ack_i(a_ack));

  iob_cache_write_buffer_channel #(.BE_DATA_W(128), .WRITE_POL(0), .WBUF_DEPTH_W(2), .MERGE_EN(1)) u_wt128 (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(b_valid), .addr_i(b_addr), .wstrb_i(b_wstrb),
    .wdata_i(b_wdata), .ready_o(b_ready), .empty_o(b_empty), .be_valid_o(b_bvalid),
    .be_addr_o(b_baddr), .be_wdata_o(b_bdata), .be_wstrb_o(b_bstrb), .be_ack_i(b_ack));

  iob_cache_write_buffer_channel #(.BE_DATA_W(32), .WRITE_POL(1), .WORD_OFFSET_W(3)) u_wb (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(c_valid), .addr_i(c_addr), .wstrb_i(c_wstrb),
    .wdata_i(c_wdata), .ready_o(c_ready), .empty_o(c_empty), .be_valid_o(c_bvalid),
    .be_addr_o(c_baddr), .be_wdata_o(c_bdata), .be_wstrb_o(c_bstrb), .be_ack_i(c_ack));

  typedef struct {
    logic        valid;
    logic [31:0] byte_addr;
    logic [3:0]  strb;
    logic [31:0] data;
    logic        ack;
    logic        rdy;
    logic        emp;
    logic        bv;
    logic [31:0] baddr;
    logic [31:0] bdata;
    logic [3:0]  bstrb;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  logic [7:0] ref_mem [32];
  logic [7:0] be_mem  [32];

  function automatic vec_t mk(input logic v, input logic [31:0] ba, input logic [3:0] st,
                              input logic [31:0] d, input logic ack, input logic rdy,
                              input logic emp, input logic bv, input logic [31:0] bba,
                              input logic [31:0] bd, input logic [3:0] bs);
    vec_t r;
    r.valid = v; r.byte_addr = ba; r.strb = st; r.data = d; r.ack = ack;
    r.rdy = rdy; r.emp = emp; r.bv = bv; r.baddr = bba; r.bdata = bd; r.bstrb = bs;
    return r;
  endfunction

  function automatic logic [255:0] mk_line(input logic [31:0] base);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + 32'(i);
    return l;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wb_idle_check(input string tag);
    check({tag, " ready"}, c_ready, 1'b1);
    check({tag, " empty"}, c_empty, 1'b1);
    check({tag, " valid"}, c_bvalid, 1'b0);
    check({tag, " strb"}, c_bstrb, 4'h0);
  endtask

  // Beats from..upto of a line, each with 0-2 random stall cycles before its ack.
  task automatic wb_beats(input logic [31:0] lbase, input logic [31:0] dbase, input int from, input int upto);
    for (int b = from; b <= upto; b++) begin
      int stall;
      stall = $urandom_range(0, 2);
      for (int s = 0; s <= stall; s++) begin
        @(negedge clk);
        c_ack = (s == stall);
        #1;
        check($sformatf("wb beat%0d valid", b), c_bvalid, 1'b1);
        check($sformatf("wb beat%0d addr", b), c_baddr, lbase + 32'(4 * b));
        check($sformatf("wb beat%0d data", b), c_bdata, dbase + 32'(b));
        check($sformatf("wb beat%0d strb", b), c_bstrb, 4'hF);
        check($sformatf("wb beat%0d ready", b), c_ready, 1'b0);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //                v  addr    strb  data          ack rdy emp bv baddr   bdata         bstrb
    vecs[0]  = mk(0, 32'h00, 4'h0, 32'h0,        0,  1,  1,  0, 32'h0,  32'h0,        4'h0);
    vecs[1]  = mk(1, 32'h00, 4'hF, 32'h11111111, 0,  1,  1,  0, 32'h0,  32'h0,        4'h0);
    vecs[2]  = mk(1, 32'h04, 4'hF, 32'h22222222, 0,  1,  0,  1, 32'h0,  32'h11111111, 4'hF);
    vecs[3]  = mk(1, 32'h08, 4'hF, 32'h33333333, 0,  1,  0,  1, 32'h0,  32'h11111111, 4'hF);
    vecs[4]  = mk(1, 32'h0C, 4'hF, 32'h44444444, 0,  1,  0,  1, 32'h0,  32'h11111111, 4'hF);
    vecs[5]  = mk(1, 32'h0C, 4'h1, 32'h000000AA, 0,  1,  0,  1, 32'h0,  32'h11111111, 4'hF);
    vecs[6]  = mk(1, 32'h10, 4'hF, 32'h55555555, 0,  0,  0,  1, 32'h0,  32'h11111111, 4'hF);
    vecs[7]  = mk(1, 32'h10, 4'hF, 32'h55555555, 1,  0,  0,  1, 32'h0,  32'h11111111, 4'hF);
    vecs[8]  = mk(1, 32'h10, 4'hF, 32'h55555555, 1,  1,  0,  1, 32'h4,  32'h22222222, 4'hF);
    vecs[9]  = mk(1, 32'h14, 4'h0, 32'h0000DEAD, 1,  1,  0,  1, 32'h8,  32'h33333333, 4'hF);
    vecs[10] = mk(0, 32'h00, 4'h0, 32'h0,        1,  1,  0,  1, 32'hC,  32'h444444AA, 4'hF);
    vecs[11] = mk(0, 32'h00, 4'h0, 32'h0,        1,  1,  0,  1, 32'h10, 32'h55555555, 4'hF);
    vecs[12] = mk(0, 32'h00, 4'h0, 32'h0,        1,  1,  1,  0, 32'h0,  32'h0,        4'h0);
    vecs[13] = mk(1, 32'h00, 4'hF, 32'h99999999, 0,  1,  1,  0, 32'h0,  32'h0,        4'h0);
    vecs[14] = mk(1, 32'h10, 4'h3, 32'h0000AABB, 0,  1,  0,  1, 32'h0,  32'h99999999, 4'hF);
    vecs[15] = mk(1, 32'h10, 4'hC, 32'h11223344, 0,  1,  0,  1, 32'h0,  32'h99999999, 4'hF);
    vecs[16] = mk(0, 32'h00, 4'h0, 32'h0,        1,  1,  0,  1, 32'h0,  32'h99999999, 4'hF);
    vecs[17] = mk(0, 32'h00, 4'h0, 32'h0,        1,  1,  0,  1, 32'h10, 32'h1122AABB, 4'hF);
    vecs[18] = mk(0, 32'h00, 4'h0, 32'h0,        0,  1,  1,  0, 32'h0,  32'h0,        4'h0);
    vecs[19] = mk(1, 32'h20, 4'h1, 32'h00000001, 0,  1,  1,  0, 32'h0,  32'h0,        4'h0);
    vecs[20] = mk(1, 32'h20, 4'h2, 32'h00000200, 0,  1,  0,  1, 32'h20, 32'h00000001, 4'h1);
    vecs[21] = mk(0, 32'h00, 4'h0, 32'h0,        1,  1,  0,  1, 32'h20, 32'h00000001, 4'h1);
    vecs[22] = mk(0, 32'h00, 4'h0, 32'h0,        1,  1,  0,  1, 32'h20, 32'h00000200, 4'h2);
    vecs[23] = mk(0, 32'h00, 4'h0, 32'h0,        0,  1,  1,  0, 32'h0,  32'h0,        4'h0);

    for (int i = 0; i < 32; i++) begin
      ref_mem[i] = 8'h0;
      be_mem[i]  = 8'h0;
    end
    a_valid = 0; a_addr = '0; a_wstrb = '0; a_wdata = '0; a_ack = 0;
    b_valid = 0; b_addr = '0; b_wstrb = '0; b_wdata = '0; b_ack = 0;
    c_valid = 0; c_addr = '0; c_wstrb = '0; c_wdata = '0; c_ack = 0;

    #1;
    wb_idle_check("wb in reset");
    check("wt128 in reset empty", b_empty, 1'b1);
    check("wt128 in reset strb", b_bstrb, 16'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // write-through table
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      a_valid = vecs[i].valid;
      a_addr  = vecs[i].byte_addr[31:2];
      a_wstrb = vecs[i].strb;
      a_wdata = vecs[i].data;
      a_ack   = vecs[i].ack;
      #1;
      check($sformatf("wt32 v%0d ready", i), a_ready, vecs[i].rdy);
      check($sformatf("wt32 v%0d empty", i), a_empty, vecs[i].emp);
      check($sformatf("wt32 v%0d be_valid", i), a_bvalid, vecs[i].bv);
      check($sformatf("wt32 v%0d be_wstrb", i), a_bstrb, vecs[i].bstrb);
      if (vecs[i].bv) begin
        check($sformatf("wt32 v%0d be_addr", i), a_baddr, vecs[i].baddr);
        check($sformatf("wt32 v%0d be_wdata", i), a_bdata, vecs[i].bdata);
      end
    end
    @(negedge clk);
    a_valid = 0; a_ack = 0;

    // BE=128: lane placement and replication
    @(negedge clk);
    b_valid = 1; b_addr = 30'h2; b_wstrb = 4'hF; b_wdata = 32'hCAFEF00D;
    #1;
    check("wt128 accept ready", b_ready, 1'b1);
    check("wt128 pre valid", b_bvalid, 1'b0);
    @(negedge clk);
    b_valid = 0;
    #1;
    check("wt128 valid N+1", b_bvalid, 1'b1);
    check("wt128 addr", b_baddr, 32'h0);
    check("wt128 strb", b_bstrb, 16'h0F00);
    check("wt128 data", b_bdata, {4{32'hCAFEF00D}});
    @(negedge clk);
    b_ack = 1;
    #1;
    check("wt128 held strb", b_bstrb, 16'h0F00);
    @(negedge clk);
    b_ack = 0; b_valid = 1; b_addr = 30'h7; b_wstrb = 4'h3; b_wdata = 32'h0000BEEF;
    #1;
    check("wt128 drained empty", b_empty, 1'b1);
    @(negedge clk);
    b_valid = 0;
    #1;
    check("wt128 top lane addr", b_baddr, 32'h10);
    check("wt128 top lane strb", b_bstrb, 16'h3000);
    @(negedge clk);
    b_ack = 1;
    @(negedge clk);
    b_ack = 0;
    #1;
    check("wt128 final empty", b_empty, 1'b1);

    // write-back: line at 0x40 with the next line (0x80) held pending
    @(negedge clk);
    c_valid = 1; c_addr = 27'h2; c_wdata = mk_line(32'hA0000000);
    #1;
    wb_idle_check("wb before accept");
    @(posedge clk);
    #1;
    c_addr = 27'h4; c_wdata = mk_line(32'hB0000000);
    wb_beats(32'h40, 32'hA0000000, 0, 7);
    @(negedge clk);
    c_ack = 0;
    #1;
    wb_idle_check("wb idle gap");
    @(posedge clk);
    #1;
    c_valid = 0;
    wb_beats(32'h80, 32'hB0000000, 0, 3);
    @(negedge clk);
    c_ack = 0;
    #1;
    check("wb beat4 addr", c_baddr, 32'h90);
    #1;
    rst_n = 1'b0;
    #1;
    wb_idle_check("wb mid-burst reset");
    #1;
    rst_n = 1'b1;

    @(negedge clk);
    c_valid = 1; c_addr = 27'h6; c_wdata = mk_line(32'hC0000000);
    #1;
    check("wb after reset ready", c_ready, 1'b1);
    @(posedge clk);
    #1;
    c_valid = 0;
    wb_beats(32'hC0, 32'hC0000000, 0, 7);
    @(negedge clk);
    c_ack = 0;
    #1;
    wb_idle_check("wb final");

    // write-through random traffic against a byte-image reference
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      a_valid = 1'($urandom_range(0, 1));
      a_addr  = 30'($urandom_range(0, 7));
      a_wstrb = 4'($urandom_range(0, 15));
      a_wdata = $urandom;
      a_ack   = ($urandom_range(0, 3) == 0);
      #1;
      if (a_valid && a_ready)
        for (int k = 0; k < 4; k++)
          if (a_wstrb[k]) ref_mem[int'(a_addr[2:0])*4 + k] = a_wdata[k*8 +: 8];
      if (a_bvalid && a_ack)
        for (int k = 0; k < 4; k++)
          if (a_bstrb[k]) be_mem[int'(a_baddr[4:0]) + k] = a_bdata[k*8 +: 8];
    end
    @(negedge clk);
    a_valid = 0; a_ack = 1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      #1;
      if (a_empty) break;
      if (a_bvalid)
        for (int k = 0; k < 4; k++)
          if (a_bstrb[k]) be_mem[int'(a_baddr[4:0]) + k] = a_bdata[k*8 +: 8];
      @(negedge clk);
    end
    check("wt32 random drain empty", a_empty, 1'b1);
    a_ack = 0;
    for (int w = 0; w < 8; w++)
      check($sformatf("wt32 image word%0d", w),
            {be_mem[w*4+3], be_mem[w*4+2], be_mem[w*4+1], be_mem[w*4]},
            {ref_mem[w*4+3], ref_mem[w*4+2], ref_mem[w*4+1], ref_mem[w*4]});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
